// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default sizes.
package tx_arbiter_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int N_REQ_DEF   = 2;
   localparam int NB_STATE    = 2;

   typedef enum logic [NB_STATE-1:0] {
      ST_IDLE      = 2'b00,
      ST_START     = 2'b01,
      ST_WAIT_DONE = 2'b10
   } state_e;

   function automatic int grant_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tx_req_slot.sv
// One-byte holding slot for a single requester; a clear in the same cycle as a new
// offer frees room for that offer, so it is captured instead of counted as an overrun.
module tx_req_slot
   import tx_arbiter_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF
)(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_clear,
   output logic               o_busy,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_overrun
);

   logic               busy_q, busy_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               overrun_q, overrun_d;

   // slot state register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         busy_q    <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   // capture / clear / overrun priority
   always_comb begin
      busy_d    = busy_q;
      data_d    = data_q;
      overrun_d = overrun_q;
      if (i_clear) begin
         busy_d = i_valid;
         if (i_valid) begin
            data_d = i_data;
         end else begin
            data_d = data_q;
         end
      end else if (i_valid) begin
         if (busy_q) begin
            overrun_d = 1'b1;
         end else begin
            busy_d = 1'b1;
            data_d = i_data;
         end
      end else begin
         busy_d = busy_q;
      end
   end

   assign o_busy    = busy_q;
   assign o_data    = data_q;
   assign o_overrun = overrun_q;

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter draining per-requester byte slots into one UART transmitter,
// with a watchdog that abandons a frame whose done tick never arrives.
module tx_arbiter
   import tx_arbiter_pkg::*;
#(
   parameter int NB_DATA    = NB_DATA_DEF,
   parameter int N_REQ      = N_REQ_DEF,
   parameter int NB_TIMEOUT = 17
)(
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [N_REQ-1:0]         i_req_valid,
   input  logic [N_REQ*NB_DATA-1:0] i_req_data,
   output logic [N_REQ-1:0]         o_req_busy,
   output logic [N_REQ-1:0]         o_req_ack,
   output logic [N_REQ-1:0]         o_overrun,
   input  logic                     i_tx_done_tick,
   output logic                     o_tx_start,
   output logic [NB_DATA-1:0]       o_tx_data,
   output logic                     o_timeout
);

   localparam int GW = grant_width(N_REQ);

   state_e                  state_q, state_d;
   logic [GW-1:0]           grant_q, grant_d;
   logic [GW-1:0]           last_grant_q, last_grant_d;
   logic [NB_DATA-1:0]      tx_data_q, tx_data_d;
   logic                    tx_start_q, tx_start_d;
   logic [N_REQ-1:0]        ack_q, ack_d;
   logic                    timeout_q, timeout_d;
   logic [NB_TIMEOUT-1:0]   wdog_q, wdog_d;

   logic [N_REQ-1:0]        busy_s;
   logic [N_REQ-1:0]        clear_s;
   logic [NB_DATA-1:0]      slot_data_s [N_REQ];
   logic                    pick_found_s;
   logic [GW-1:0]           pick_idx_s;
   logic [GW:0]             scan_sum_s;

   for (genvar k = 0; k < N_REQ; k++) begin : g_slot
      tx_req_slot #(.NB_DATA(NB_DATA)) u_slot (
         .i_clk     (i_clk),
         .i_reset   (i_reset),
         .i_valid   (i_req_valid[k]),
         .i_data    (i_req_data[k*NB_DATA +: NB_DATA]),
         .i_clear   (clear_s[k]),
         .o_busy    (busy_s[k]),
         .o_data    (slot_data_s[k]),
         .o_overrun (o_overrun[k])
      );
   end

   // round-robin scan; walking offsets downward lets the nearest busy slot win
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = '0;
      scan_sum_s   = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         scan_sum_s = {1'b0, last_grant_q} + (GW+1)'(i);
         if (scan_sum_s >= (GW+1)'(N_REQ)) begin
            scan_sum_s = scan_sum_s - (GW+1)'(N_REQ);
         end else begin
            scan_sum_s = scan_sum_s;
         end
         if (busy_s[scan_sum_s[GW-1:0]]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = scan_sum_s[GW-1:0];
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // arbiter state register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(N_REQ-1);
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
         ack_q        <= '0;
         timeout_q    <= 1'b0;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         ack_q        <= ack_d;
         timeout_q    <= timeout_d;
         wdog_q       <= wdog_d;
      end
   end

   // next-state logic; tx_start is raised on entry to START so it is a flop output
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      tx_data_d    = tx_data_q;
      tx_start_d   = 1'b0;
      ack_d        = '0;
      timeout_d    = timeout_q;
      wdog_d       = wdog_q;
      clear_s      = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found_s) begin
               grant_d    = pick_idx_s;
               tx_data_d  = slot_data_s[pick_idx_s];
               tx_start_d = 1'b1;
               state_d    = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            wdog_d  = '0;
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (i_tx_done_tick) begin
               clear_s[grant_q] = 1'b1;
               ack_d[grant_q]   = 1'b1;
               last_grant_d     = grant_q;
               state_d          = ST_IDLE;
            end else if (wdog_q == {NB_TIMEOUT{1'b1}}) begin
               clear_s[grant_q] = 1'b1;
               timeout_d        = 1'b1;
               last_grant_d     = grant_q;
               state_d          = ST_IDLE;
            end else begin
               wdog_d = wdog_q + NB_TIMEOUT'(1'b1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign o_req_busy = busy_s;
   assign o_req_ack  = ack_q;
   assign o_tx_start = tx_start_q;
   assign o_tx_data  = tx_data_q;
   assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a per-cycle vector table plus hand sequences for
// the watchdog and mid-frame reset cases.
module tb_tx_arbiter;

   localparam int NBT = 6;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_busy;
   logic [1:0]  req_ack;
   logic [1:0]  overrun;
   logic        done_tick;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        timeout;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic       rst;
      logic [1:0] vld;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       done;
      logic [1:0] e_busy;
      logic [1:0] e_ack;
      logic       e_start;
      logic [7:0] e_data;
      logic [1:0] e_ovr;
      logic       e_to;
   } vec_t;

   vec_t vq[$];

   tx_arbiter #(.NB_DATA(8), .N_REQ(2), .NB_TIMEOUT(NBT)) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_req_valid    (req_valid),
      .i_req_data     (req_data),
      .o_req_busy     (req_busy),
      .o_req_ack      (req_ack),
      .o_overrun      (overrun),
      .i_tx_done_tick (done_tick),
      .o_tx_start     (tx_start),
      .o_tx_data      (tx_data),
      .o_timeout      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                      input logic d);
      rst       = r;
      req_valid = v;
      req_data  = {b, a};
      done_tick = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                      input logic d, input logic [1:0] eb, input logic [1:0] ea, input logic es,
                      input logic [7:0] ed, input logic [1:0] eo, input logic et);
      vec_t x;
      x.rst = r; x.vld = v; x.d0 = a; x.d1 = b; x.done = d;
      x.e_busy = eb; x.e_ack = ea; x.e_start = es; x.e_data = ed; x.e_ovr = eo; x.e_to = et;
      vq.push_back(x);
   endtask

   task automatic chk_all(input string tag, input int idx, input logic [1:0] eb, input logic [1:0] ea,
                          input logic es, input logic [7:0] ed, input logic [1:0] eo, input logic et);
      chk({tag, " busy"},    idx, 32'(req_busy), 32'(eb));
      chk({tag, " ack"},     idx, 32'(req_ack),  32'(ea));
      chk({tag, " start"},   idx, 32'(tx_start), 32'(es));
      chk({tag, " data"},    idx, 32'(tx_data),  32'(ed));
      chk({tag, " overrun"}, idx, 32'(overrun),  32'(eo));
      chk({tag, " timeout"}, idx, 32'(timeout),  32'(et));
   endtask

   initial begin
      int n;
      logic [1:0] ack_seen;
      rst = 1'b1; req_valid = 2'b00; req_data = 16'h0000; done_tick = 1'b0;
      @(posedge clk);
      #1;

      //   rst   vld    d0     d1     done  busy   ack    st    data   ovr    to
      add(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      // single byte, 2-cycle latency to start
      add(1'b0, 2'b01, 8'h3C, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h3C, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0, 8'h3C, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b01, 1'b0, 8'h3C, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h3C, 2'b00, 1'b0);
      add(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      // simultaneous pair, twice: order 11,22,11,22
      add(1'b0, 2'b11, 8'h11, 8'h22, 1'b0, 2'b11, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 2'b00, 1'b1, 8'h11, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 2'b00, 1'b0, 8'h11, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b01, 1'b0, 8'h11, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 2'b00, 1'b1, 8'h22, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 2'b00, 1'b0, 8'h22, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b10, 1'b0, 8'h22, 2'b00, 1'b0);
      add(1'b0, 2'b11, 8'h11, 8'h22, 1'b0, 2'b11, 2'b00, 1'b0, 8'h22, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 2'b00, 1'b1, 8'h11, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 2'b00, 1'b0, 8'h11, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b01, 1'b0, 8'h11, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 2'b00, 1'b1, 8'h22, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 2'b00, 1'b0, 8'h22, 2'b00, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b10, 1'b0, 8'h22, 2'b00, 1'b0);
      // overrun on slot 1: 0x77 sent, 0x55 dropped
      add(1'b0, 2'b10, 8'h00, 8'h77, 1'b0, 2'b10, 2'b00, 1'b0, 8'h22, 2'b00, 1'b0);
      add(1'b0, 2'b10, 8'h00, 8'h55, 1'b0, 2'b10, 2'b00, 1'b1, 8'h77, 2'b10, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 2'b00, 1'b0, 8'h77, 2'b10, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b10, 1'b0, 8'h77, 2'b10, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h77, 2'b10, 1'b0);
      // refill slot 0 in its own completion cycle
      add(1'b0, 2'b01, 8'h5A, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0, 8'h77, 2'b10, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h5A, 2'b10, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0, 8'h5A, 2'b10, 1'b0);
      add(1'b0, 2'b01, 8'hA5, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h5A, 2'b10, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'hA5, 2'b10, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0, 8'hA5, 2'b10, 1'b0);
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b01, 1'b0, 8'hA5, 2'b10, 1'b0);
      // done tick while idle is ignored
      add(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'hA5, 2'b10, 1'b0);

      for (int i = 0; i < vq.size(); i++) begin
         cyc(vq[i].rst, vq[i].vld, vq[i].d0, vq[i].d1, vq[i].done);
         chk_all("vec", i, vq[i].e_busy, vq[i].e_ack, vq[i].e_start, vq[i].e_data, vq[i].e_ovr, vq[i].e_to);
      end

      // watchdog: done tick withheld for slot 0, slot 1 served afterwards
      cyc(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
      cyc(1'b0, 2'b11, 8'hC1, 8'hC2, 1'b0);
      cyc(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
      chk_all("wd start", 0, 2'b11, 2'b00, 1'b1, 8'hC1, 2'b00, 1'b0);
      n = 0;
      ack_seen = 2'b00;
      while (n < 300 && timeout !== 1'b1) begin
         cyc(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
         ack_seen = ack_seen | req_ack;
         n++;
      end
      chk("wd latency", 0, 32'(n), 32'((1 << NBT) + 1));
      chk("wd no ack", 0, 32'(ack_seen), 32'd0);
      chk_all("wd fired", 0, 2'b10, 2'b00, 1'b0, 8'hC1, 2'b00, 1'b1);
      cyc(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
      chk_all("wd next", 0, 2'b10, 2'b00, 1'b1, 8'hC2, 2'b00, 1'b1);
      cyc(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
      cyc(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
      chk_all("wd ack1", 0, 2'b00, 2'b10, 1'b0, 8'hC2, 2'b00, 1'b1);

      // reset in WAIT_DONE with both slots full
      cyc(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
      cyc(1'b0, 2'b11, 8'hD1, 8'hD2, 1'b0);
      cyc(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
      cyc(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
      chk_all("rst pre", 0, 2'b11, 2'b00, 1'b0, 8'hD1, 2'b00, 1'b0);
      cyc(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
      chk_all("rst mid", 0, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      cyc(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
      chk_all("rst late done", 0, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      cyc(1'b0, 2'b11, 8'hE1, 8'hE2, 1'b0);
      cyc(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
      chk_all("rst first grant", 0, 2'b11, 2'b00, 1'b1, 8'hE1, 2'b00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
